udp_depacketizer: RTL and testbench
===================================

Name: udp_depacketizer

Overview:
- Receive-side counterpart of the SDR Ethernet/UDP/IQ framer.
- Consumes byte-wide AXI-Stream frames from the MAC RX FIFO and validates the Ethernet/IPv4/UDP header plus the 64-bit sequence field.
- Unpacks IQ payload into 32-bit samples for the Serializer feeding the DAC/LVDS TX path.
- Frames addressed elsewhere, malformed or truncated are discarded and counted.

Parameters:
- LOCAL_MAC, 48'h021234567890, destination MAC accepted.
- LOCAL_IP, {8'd10,8'd0,8'd0,8'd2}, destination IP accepted.
- LOCAL_PORT, 16'd32179, destination UDP port accepted.
- NUM_SAMPLES, 366, IQ samples per frame; IQ_LEN=4*NUM_SAMPLES, UDP_LEN=IQ_LEN+16, IP_LEN=UDP_LEN+20.

Ports:
- clk  in  1  system clock, same domain as MAC RX FIFO read side.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- rx_tdata  in  8  frame byte from MAC.
- rx_tvalid  in  1  byte valid.
- rx_tready  out  1  byte accepted when rx_tvalid&&rx_tready.
- rx_tlast  in  1  last byte of frame.
- rx_tuser  in  1  MAC error flag, meaningful with rx_tlast.
- iq_tdata  out  32  {I[15:0],Q[15:0]}.
- iq_tvalid  out  1  sample valid.
- iq_tready  in  1  downstream ready.
- seq_gap  out  1  one-cycle pulse: received sequence != expected.
- good_frames  out  16  count of fully accepted frames, wraps.
- drop_frames  out  16  count of rejected/truncated/errored frames, wraps.

Behaviour:
- Reset (rst==0 at a clk edge): state=HDR, byte index=0, iq_tvalid=0, rx_tready=0, seq_gap=0, both counters=0, seq_valid=0. rx_tready goes 1 the cycle after reset deasserts.
- States:
  - HDR: bytes 0..49. rx_tready=1.
  - PAYLOAD: bytes 50..50+IQ_LEN-1.
  - DROP: discard until tlast. rx_tready=1.
  - TAIL: extra bytes after payload until tlast. rx_tready=1.
- HDR checked fields (byte offset: expected); any mismatch sets sticky hdr_bad:
  - 0-5: LOCAL_MAC, MSB first.
  - 12-13: 08 00.
  - 14: 45.
  - 16-17: IP_LEN, big-endian.
  - 23: 11.
  - 30-33: LOCAL_IP.
  - 36-37: LOCAL_PORT.
  - 38-39: UDP_LEN.
- HDR ignored fields: src MAC, DSCP, IP ID, fragment, TTL, checksums, src IP, src port.
- Bytes 42-49 carry the sequence number, little-endian, into a 64-bit register.
- At byte 49: hdr_bad -> DROP. Otherwise -> PAYLOAD. If seq_valid && seq != last_seq+1, pulse seq_gap. Then last_seq<=seq and seq_valid<=1. seq_gap fires on sequence-checked frames only.
- PAYLOAD byte order per sample: I lo, I hi, Q lo, Q hi. The 4th byte loads the output register: iq_tvalid<=1.
- PAYLOAD backpressure: rx_tready = ~iq_tvalid || iq_tready (single output register, zero-bubble). Output holds stable while iq_tvalid&&!iq_tready.
- Latency: last Q byte accepted at edge N -> iq_tvalid high after edge N.
- Payload end:
  - After IQ_LEN bytes, tlast on the final byte: good_frames++ if !rx_tuser, else drop_frames++ (samples already emitted are not recalled). Return to HDR.
  - No tlast on the final byte: -> TAIL. At tlast in TAIL: drop_frames++, then HDR.
- tlast before the end of HDR or PAYLOAD (runt): drop_frames++, partial sample discarded, -> HDR.
- tlast in DROP: drop_frames++, -> HDR.
- Byte index/hdr_bad clear on every return to HDR. Sequence bytes of dropped frames do not update last_seq.
- last_seq+1 wraps at 2^64.

Decomposition:
- Package sdr_net_pkg: header byte offsets, ETHERTYPE_IPV4, IPV4_VER_IHL, PROTO_UDP, HDR_LEN=50, and the length-derivation functions (shared with the TX framer so both agree).
- Sub-module iq_unpack: byte-to-32-bit assembler with the output register and ready logic. Everything else lives in the top FSM.

Test Plan:
- Valid frame, seq=0, 366 samples (I=k, Q=-k), iq_tready=1 -> 366 beats {k,-k} in order; good_frames=1; seq_gap never pulses.
- Two valid frames seq=5 then seq=7 -> one seq_gap pulse at byte 49 of the second frame; good_frames=2.
- Dest MAC byte 5 = 0xBB -> zero iq beats; drop_frames=1; following valid frame accepted normally.
- Runt: tlast after 10 payload bytes -> exactly 2 iq beats; drop_frames=1; next frame starts at HDR.
- iq_tready toggled 1/0 at random during payload -> no lost or duplicated sample; iq_tdata stable while stalled.
- rst=0 for one cycle mid-payload -> iq_tvalid=0 and counters=0 next cycle; the remaining bytes of that frame are parsed as a new header and counted as a drop.

Source files
------------

// File: rtl/sdr_net_pkg.sv
// Shared Ethernet/IPv4/UDP/IQ framing constants for the SDR link (RX and TX sides).
package sdr_net_pkg;

  // Header byte offsets within the Ethernet frame
  localparam int OFF_ETH_DST   = 0;
  localparam int OFF_ETHTYPE   = 12;
  localparam int OFF_VER_IHL   = 14;
  localparam int OFF_IP_LEN    = 16;
  localparam int OFF_PROTO     = 23;
  localparam int OFF_IP_DST    = 30;
  localparam int OFF_UDP_DPORT = 36;
  localparam int OFF_UDP_LEN   = 38;
  localparam int OFF_SEQ       = 42;
  localparam int HDR_LEN       = 50;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [7:0]  PROTO_UDP      = 8'h11;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP,
    ST_TAIL
  } rx_state_e;

  // IQ payload bytes: 16-bit I + 16-bit Q per sample
  function automatic int iq_len(input int n);
    return 4 * n;
  endfunction

  // UDP length covers the 8-byte UDP header and the 8-byte sequence field
  function automatic int udp_len(input int n);
    return iq_len(n) + 16;
  endfunction

  // IPv4 total length adds the 20-byte option-less IP header
  function automatic int ip_len(input int n);
    return udp_len(n) + 20;
  endfunction

endpackage

// File: rtl/iq_unpack.sv
// Byte-to-sample assembler: collects I lo, I hi, Q lo, Q hi into one
// {I,Q} word held in a single zero-bubble output register.
module iq_unpack (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] part_q, part_d;
  logic [31:0] data_q, data_d;
  logic        vld_q, vld_d;

  // A byte may enter whenever the output slot is empty or draining this cycle
  assign in_ready  = ~vld_q | out_ready;
  assign out_data  = data_q;
  assign out_valid = vld_q;

  // Assemble bytes; the 4th byte of a sample loads the output register
  always_comb begin
    lane_d = lane_q;
    part_d = part_q;
    data_d = data_q;
    vld_d  = vld_q;
    if (vld_q && out_ready) vld_d = 1'b0;
    if (clr) begin
      lane_d = 2'd0;
    end else if (in_valid) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0: part_d[7:0]   = in_data;
        2'd1: part_d[15:8]  = in_data;
        2'd2: part_d[23:16] = in_data;
        default: begin
          data_d = {part_q[15:8], part_q[7:0], in_data, part_q[23:16]};
          vld_d  = 1'b1;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_q <= 2'd0;
      part_q <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      part_q <= part_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/udp_depacketizer.sv
// Receive-side Ethernet/IPv4/UDP/IQ deframer: validates the header and
// sequence number, unpacks IQ payload, and counts good/dropped frames.
module udp_depacketizer
  import sdr_net_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC   = 48'h021234567890,
  parameter logic [31:0] LOCAL_IP    = {8'd10, 8'd0, 8'd0, 8'd2},
  parameter logic [15:0] LOCAL_PORT  = 16'd32179,
  parameter int          NUM_SAMPLES = 366
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  input  logic        rx_tlast,
  input  logic        rx_tuser,
  output logic [31:0] iq_tdata,
  output logic        iq_tvalid,
  input  logic        iq_tready,
  output logic        seq_gap,
  output logic [15:0] good_frames,
  output logic [15:0] drop_frames
);

  localparam int          IQ_LEN    = iq_len(NUM_SAMPLES);
  localparam int          LAST_IDX  = HDR_LEN + IQ_LEN - 1;
  localparam logic [15:0] UDP_LEN_W = 16'(udp_len(NUM_SAMPLES));
  localparam logic [15:0] IP_LEN_W  = 16'(ip_len(NUM_SAMPLES));

  rx_state_e   state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic        hdr_bad_q, hdr_bad_d;
  logic [63:0] seq_q, seq_d;
  logic [63:0] last_seq_q, last_seq_d;
  logic        seq_valid_q, seq_valid_d;
  logic        gap_q, gap_d;
  logic [15:0] good_q, good_d;
  logic [15:0] drop_q, drop_d;
  logic        rdy_en_q;

  logic        up_in_ready, up_valid, up_clr, acc, restart;
  logic        hdr_chk;
  logic [7:0]  hdr_exp;
  logic [2:0]  seq_lane;
  logic [63:0] seq_full;

  // Input is held off for the first cycle out of reset; payload follows the unpacker
  assign rx_tready = rdy_en_q & ((state_q != ST_PAYLOAD) | up_in_ready);
  assign acc       = rx_tvalid & rx_tready;
  assign up_valid  = acc & (state_q == ST_PAYLOAD);
  assign up_clr    = (state_q != ST_PAYLOAD);
  assign seq_lane  = 3'(idx_q - 16'(OFF_SEQ));
  assign seq_full  = {rx_tdata, seq_q[55:0]};

  assign seq_gap     = gap_q;
  assign good_frames = good_q;
  assign drop_frames = drop_q;

  // Expected value for each checked header byte; unchecked offsets are don't-care
  always_comb begin
    hdr_chk = 1'b1;
    hdr_exp = 8'h00;
    case (idx_q)
      16'(OFF_ETH_DST + 0):   hdr_exp = LOCAL_MAC[47:40];
      16'(OFF_ETH_DST + 1):   hdr_exp = LOCAL_MAC[39:32];
      16'(OFF_ETH_DST + 2):   hdr_exp = LOCAL_MAC[31:24];
      16'(OFF_ETH_DST + 3):   hdr_exp = LOCAL_MAC[23:16];
      16'(OFF_ETH_DST + 4):   hdr_exp = LOCAL_MAC[15:8];
      16'(OFF_ETH_DST + 5):   hdr_exp = LOCAL_MAC[7:0];
      16'(OFF_ETHTYPE + 0):   hdr_exp = ETHERTYPE_IPV4[15:8];
      16'(OFF_ETHTYPE + 1):   hdr_exp = ETHERTYPE_IPV4[7:0];
      16'(OFF_VER_IHL):       hdr_exp = IPV4_VER_IHL;
      16'(OFF_IP_LEN + 0):    hdr_exp = IP_LEN_W[15:8];
      16'(OFF_IP_LEN + 1):    hdr_exp = IP_LEN_W[7:0];
      16'(OFF_PROTO):         hdr_exp = PROTO_UDP;
      16'(OFF_IP_DST + 0):    hdr_exp = LOCAL_IP[31:24];
      16'(OFF_IP_DST + 1):    hdr_exp = LOCAL_IP[23:16];
      16'(OFF_IP_DST + 2):    hdr_exp = LOCAL_IP[15:8];
      16'(OFF_IP_DST + 3):    hdr_exp = LOCAL_IP[7:0];
      16'(OFF_UDP_DPORT + 0): hdr_exp = LOCAL_PORT[15:8];
      16'(OFF_UDP_DPORT + 1): hdr_exp = LOCAL_PORT[7:0];
      16'(OFF_UDP_LEN + 0):   hdr_exp = UDP_LEN_W[15:8];
      16'(OFF_UDP_LEN + 1):   hdr_exp = UDP_LEN_W[7:0];
      default:                hdr_chk = 1'b0;
    endcase
  end

  // Frame FSM: header check, sequence tracking, payload/tail/drop handling
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hdr_bad_d   = hdr_bad_q;
    seq_d       = seq_q;
    last_seq_d  = last_seq_q;
    seq_valid_d = seq_valid_q;
    gap_d       = 1'b0;
    good_d      = good_q;
    drop_d      = drop_q;
    restart     = 1'b0;
    case (state_q)
      ST_HDR: if (acc) begin
        idx_d = idx_q + 16'd1;
        if (hdr_chk && rx_tdata != hdr_exp) hdr_bad_d = 1'b1;
        if (idx_q >= 16'(OFF_SEQ)) seq_d[8*seq_lane +: 8] = rx_tdata;
        if (rx_tlast) begin
          drop_d  = drop_q + 16'd1;
          restart = 1'b1;
        end else if (idx_q == 16'(HDR_LEN - 1)) begin
          if (hdr_bad_d) begin
            state_d = ST_DROP;
          end else begin
            state_d     = ST_PAYLOAD;
            gap_d       = seq_valid_q && (seq_full != last_seq_q + 64'd1);
            last_seq_d  = seq_full;
            seq_valid_d = 1'b1;
          end
        end
      end
      ST_PAYLOAD: if (acc) begin
        idx_d = idx_q + 16'd1;
        if (idx_q == 16'(LAST_IDX)) begin
          if (rx_tlast) begin
            if (rx_tuser) drop_d = drop_q + 16'd1;
            else          good_d = good_q + 16'd1;
            restart = 1'b1;
          end else begin
            state_d = ST_TAIL;
          end
        end else if (rx_tlast) begin
          drop_d  = drop_q + 16'd1;
          restart = 1'b1;
        end
      end
      default: if (acc && rx_tlast) begin
        drop_d  = drop_q + 16'd1;
        restart = 1'b1;
      end
    endcase
    if (restart) begin
      state_d   = ST_HDR;
      idx_d     = 16'd0;
      hdr_bad_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_HDR;
      idx_q       <= 16'd0;
      hdr_bad_q   <= 1'b0;
      seq_q       <= '0;
      last_seq_q  <= '0;
      seq_valid_q <= 1'b0;
      gap_q       <= 1'b0;
      good_q      <= 16'd0;
      drop_q      <= 16'd0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hdr_bad_q   <= hdr_bad_d;
      seq_q       <= seq_d;
      last_seq_q  <= last_seq_d;
      seq_valid_q <= seq_valid_d;
      gap_q       <= gap_d;
      good_q      <= good_d;
      drop_q      <= drop_d;
      rdy_en_q    <= 1'b1;
    end
  end

  iq_unpack u_unpack (
    .clk       (clk),
    .rst       (rst),
    .clr       (up_clr),
    .in_data   (rx_tdata),
    .in_valid  (up_valid),
    .in_ready  (up_in_ready),
    .out_data  (iq_tdata),
    .out_valid (iq_tvalid),
    .out_ready (iq_tready)
  );

endmodule

// File: tb/tb_udp_depacketizer.sv
// Directed bench for udp_depacketizer with a queue-based IQ scoreboard.
module tb_udp_depacketizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid, rx_tready, rx_tlast, rx_tuser;
  logic [31:0] iq_tdata;
  logic        iq_tvalid, iq_tready;
  logic        seq_gap;
  logic [15:0] good_frames, drop_frames;

  int          total = 0;
  int          bad   = 0;
  int          gap_cnt = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  frm[$];
  logic        rand_rdy = 1'b0;
  logic        stalled = 1'b0;
  logic [31:0] stall_d = '0;

  always #5 clk = ~clk;

  udp_depacketizer dut (
    .clk         (clk),
    .rst         (rst),
    .rx_tdata    (rx_tdata),
    .rx_tvalid   (rx_tvalid),
    .rx_tready   (rx_tready),
    .rx_tlast    (rx_tlast),
    .rx_tuser    (rx_tuser),
    .iq_tdata    (iq_tdata),
    .iq_tvalid   (iq_tvalid),
    .iq_tready   (iq_tready),
    .seq_gap     (seq_gap),
    .good_frames (good_frames),
    .drop_frames (drop_frames)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Header: 42 fixed bytes (dst MAC byte 5 overridable), 8 sequence bytes LE, then payload
  task automatic build_frame(input logic [63:0] seq, input logic [7:0] mac5,
                             input int npay, input int ntail);
    logic [7:0] h[42];
    logic [15:0] iv, qv;
    h = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h90,
          8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA,
          8'h08, 8'h00, 8'h45, 8'h00, 8'h05, 8'hDC,
          8'h00, 8'h01, 8'h40, 8'h00, 8'h40, 8'h11,
          8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h01,
          8'h0A, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34,
          8'h7D, 8'hB3, 8'h05, 8'hC8, 8'h00, 8'h00};
    h[5] = mac5;
    frm.delete();
    for (int i = 0; i < 42; i++) frm.push_back(h[i]);
    for (int i = 0; i < 8; i++) frm.push_back(seq[8*i +: 8]);
    for (int b = 0; b < npay; b++) begin
      iv = 16'(b / 4);
      qv = 16'(-(b / 4));
      case (b % 4)
        0: frm.push_back(iv[7:0]);
        1: frm.push_back(iv[15:8]);
        2: frm.push_back(qv[7:0]);
        default: frm.push_back(qv[15:8]);
      endcase
    end
    for (int i = 0; i < ntail; i++) frm.push_back(8'h5A);
  endtask

  task automatic push_samples(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({16'(k), 16'(-k)});
  endtask

  // Called just after a rising edge; returns just after the edge that took the byte
  task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
    logic ok;
    int   n;
    n = 0;
    rx_tdata = d; rx_tvalid = 1'b1; rx_tlast = l; rx_tuser = u;
    forever begin
      @(negedge clk);
      ok = rx_tready;
      @(posedge clk); #1;
      if (ok === 1'b1) break;
      n++;
      if (n > 2000) begin
        $display("FAIL rx_timeout: rx_tready stuck at %b, expected 1", rx_tready);
        $fatal(1);
      end
    end
    rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input bit tl, input bit user);
    for (int i = from; i <= to; i++) send_byte(frm[i], tl && i == to, user && i == to);
  endtask

  task automatic send_frame(input bit user);
    send_range(0, frm.size() - 1, 1'b1, user);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || iq_tvalid === 1'b1); i++) @(posedge clk);
    #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; rx_tdata = '0; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
    iq_tready = 1'b1;
    fork
      // Monitor: pops the scoreboard on each handshake, checks stall stability, counts gaps
      forever begin
        @(negedge clk);
        if (seq_gap === 1'b1) gap_cnt++;
        if (rst === 1'b1 && iq_tvalid === 1'b1) begin
          if (stalled) chk("stall_hold", 64'(iq_tdata), 64'(stall_d));
          if (iq_tready === 1'b1) begin
            stalled = 1'b0;
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL extra_beat: got %h expected no beat", iq_tdata);
            end else begin
              chk("iq_beat", 64'(iq_tdata), 64'(exp_q.pop_front()));
            end
          end else begin
            stalled = 1'b1;
            stall_d = iq_tdata;
          end
        end else begin
          stalled = 1'b0;
        end
      end
      // Random downstream backpressure when enabled
      forever begin
        @(posedge clk); #1;
        if (rand_rdy) iq_tready = 1'($urandom_range(0, 1));
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_tready", 64'(rx_tready), 64'd0);
        chk("rst_iq_tvalid", 64'(iq_tvalid), 64'd0);
        chk("rst_seq_gap", 64'(seq_gap), 64'd0);
        chk("rst_good", 64'(good_frames), 64'd0);
        chk("rst_drop", 64'(drop_frames), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rdy_after_rst", 64'(rx_tready), 64'd1);
        @(posedge clk); #1;

        // Full frame, seq 0
        build_frame(64'd0, 8'h90, 1464, 0); push_samples(366); send_frame(1'b0); drain();
        chk("t1_good", 64'(good_frames), 64'd1);
        chk("t1_drop", 64'(drop_frames), 64'd0);
        chk("t1_gap", 64'(gap_cnt), 64'd0);

        // Sequence 5 then 7 after a fresh reset
        @(posedge clk); #1; do_reset();
        build_frame(64'd5, 8'h90, 1464, 0); push_samples(366); send_frame(1'b0);
        chk("t2_gap_first", 64'(gap_cnt), 64'd0);
        build_frame(64'd7, 8'h90, 1464, 0); push_samples(366); send_frame(1'b0); drain();
        chk("t2_gap_second", 64'(gap_cnt), 64'd1);
        chk("t2_good", 64'(good_frames), 64'd2);

        // Wrong destination MAC, then a normal frame
        @(posedge clk); #1;
        build_frame(64'd8, 8'hBB, 1464, 0); send_frame(1'b0); drain();
        chk("t3_drop", 64'(drop_frames), 64'd1);
        chk("t3_good", 64'(good_frames), 64'd2);
        @(posedge clk); #1;
        build_frame(64'd8, 8'h90, 1464, 0); push_samples(366); send_frame(1'b0); drain();
        chk("t3_good_after", 64'(good_frames), 64'd3);
        chk("t3_gap", 64'(gap_cnt), 64'd1);

        // Runt: tlast on the 10th payload byte yields two samples
        @(posedge clk); #1;
        build_frame(64'd9, 8'h90, 10, 0); push_samples(2); send_frame(1'b0); drain();
        chk("t4_drop", 64'(drop_frames), 64'd2);
        @(posedge clk); #1;
        build_frame(64'd10, 8'h90, 1464, 0); push_samples(366); send_frame(1'b0); drain();
        chk("t4_good_after", 64'(good_frames), 64'd4);
        chk("t4_gap", 64'(gap_cnt), 64'd1);

        // Random backpressure
        @(posedge clk); #1;
        rand_rdy = 1'b1;
        build_frame(64'd11, 8'h90, 1464, 0); push_samples(366); send_frame(1'b0); drain();
        rand_rdy = 1'b0; iq_tready = 1'b1;
        chk("t5_good", 64'(good_frames), 64'd5);

        // MAC error flag on final byte: samples still emitted, frame dropped
        @(posedge clk); #1;
        build_frame(64'd12, 8'h90, 1464, 0); push_samples(366); send_frame(1'b1); drain();
        chk("t6_drop", 64'(drop_frames), 64'd3);
        chk("t6_good", 64'(good_frames), 64'd5);

        // Trailing bytes past the payload
        @(posedge clk); #1;
        build_frame(64'd13, 8'h90, 1464, 3); push_samples(366); send_frame(1'b0); drain();
        chk("t7_drop", 64'(drop_frames), 64'd4);
        chk("t7_good", 64'(good_frames), 64'd5);

        // Reset mid-payload; remainder parsed as a bad header
        @(posedge clk); #1;
        build_frame(64'd14, 8'h90, 1464, 0); push_samples(25);
        send_range(0, 149, 1'b0, 1'b0);
        drain();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t8_iq_tvalid", 64'(iq_tvalid), 64'd0);
        chk("t8_good_clr", 64'(good_frames), 64'd0);
        chk("t8_drop_clr", 64'(drop_frames), 64'd0);
        chk("t8_rdy_held", 64'(rx_tready), 64'd0);
        @(posedge clk); #1;
        send_range(150, frm.size() - 1, 1'b1, 1'b0); drain();
        chk("t8_drop", 64'(drop_frames), 64'd1);
        chk("t8_good", 64'(good_frames), 64'd0);
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
